spi_ad_slave: RTL and testbench

- 3-wire SPI responder that sits on the far end of the converter configuration link, in the daughterboard-emulation FPGA and as a synthesizable bus-functional target for link bring-up.
- Decodes 24-bit frames: 16-bit command {R/W, W1, W0, A[12:0]} followed by 8 data bits. Services them from a local 8-bit register bank.
- Exposes a write-strobe and read port to the fabric.
- SPI pins are oversampled in the system clock domain; there is no logic clocked by SPI_CLK.

---
 rtl/spi_ad_slave.sv | 123 ++++++++++++
 tb/tb_spi_ad_slave.sv | 132 +++++++++++++
 2 files changed

// File: rtl/spi_ad_slave.sv
// spi_ad_slave: 3-wire SPI register target with oversampled pins, 8-bit register bank and fabric ports
module spi_ad_slave #(
  parameter int NUM_REGS = 16,
  parameter logic [7:0] CHIP_ID = 8'h5A,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        SPI_CLK,
  input  logic                        SPI_CS,
  input  logic                        SPI_Data_in,
  output logic                        SPI_Data_out,
  output logic                        SPI_Data_oe,
  input  logic [$clog2(NUM_REGS)-1:0] Loc_Addr,
  output logic [7:0]                  Loc_q,
  output logic                        Wr_Stb,
  output logic [12:0]                 Wr_Addr,
  output logic [7:0]                  Wr_Data,
  output logic                        Frame_Err,
  output logic                        Busy
);
  localparam int AW = $clog2(NUM_REGS);
  localparam logic [12:0] NR = 13'(NUM_REGS);
  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;
  state_t state, nxt;
  logic [SYNC_STAGES-1:0] sclk_q, cs_q, sdi_q;
  logic sclk_d, cs_d, sclk_s, cs_s, sdi, rise, fall, cs_fall, cs_rise;
  logic [4:0] cnt;
  logic [14:0] sr;
  logic [15:0] cmd;
  logic rw, wr_ok, cmd_valid;
  logic [12:0] addr;
  logic [7:0] tx, rd_val;
  logic [7:0] regs [NUM_REGS];
  assign sclk_s = sclk_q[SYNC_STAGES-1];
  assign cs_s = cs_q[SYNC_STAGES-1];
  assign sdi = sdi_q[SYNC_STAGES-1];
  assign rise = sclk_s & ~sclk_d;
  assign fall = ~sclk_s & sclk_d;
  assign cs_fall = ~cs_s & cs_d;
  assign cs_rise = cs_s & ~cs_d;
  assign cmd = {sr, sdi};
  assign cmd_valid = cmd[14:13] == 2'b00 && cmd[12:0] < NR;
  assign rd_val = !cmd_valid ? 8'h00 : cmd[12:0] == 13'd0 ? CHIP_ID : regs[cmd[AW-1:0]];
  assign Busy = state != IDLE;
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = cs_fall ? CMD : IDLE;
      CMD: nxt = rise && cnt == 5'd15 ? DATA : CMD;
      DATA: nxt = (rw ? fall && cnt == 5'd24 : rise && cnt == 5'd23) ? DONE : DATA;
      default: nxt = DONE;
    endcase
    if (cs_rise) nxt = IDLE;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      sclk_q <= '0;
      cs_q <= '0;
      sdi_q <= '0;
      sclk_d <= 1'b0;
      cs_d <= 1'b0;
      cnt <= '0;
      sr <= '0;
      rw <= 1'b0;
      wr_ok <= 1'b0;
      addr <= '0;
      tx <= '0;
      SPI_Data_out <= 1'b0;
      SPI_Data_oe <= 1'b0;
      Loc_q <= '0;
      Wr_Stb <= 1'b0;
      Wr_Addr <= '0;
      Wr_Data <= '0;
      Frame_Err <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      state <= nxt;
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], SPI_CLK};
      cs_q <= {cs_q[SYNC_STAGES-2:0], SPI_CS};
      sdi_q <= {sdi_q[SYNC_STAGES-2:0], SPI_Data_in};
      sclk_d <= sclk_s;
      cs_d <= cs_s;
      Wr_Stb <= 1'b0;
      Frame_Err <= 1'b0;
      Loc_q <= Loc_Addr == '0 ? CHIP_ID : regs[Loc_Addr];
      if (cs_rise) begin
        SPI_Data_oe <= 1'b0;
        SPI_Data_out <= 1'b0;
      end else if (state == IDLE) begin
        cnt <= '0;
      end else if (state == CMD && rise) begin
        sr <= cmd[14:0];
        cnt <= cnt + 5'd1;
        if (cnt == 5'd15) begin
          rw <= cmd[15];
          addr <= cmd[12:0];
          wr_ok <= cmd_valid && cmd[12:0] != 13'd0;
          tx <= rd_val;
          Frame_Err <= cmd[15] && !cmd_valid;
        end
      end else if (state == DATA && rw && fall) begin
        SPI_Data_oe <= cnt != 5'd24;
        SPI_Data_out <= tx[7] & (cnt != 5'd24);
        tx <= {tx[6:0], 1'b0};
      end else if (state == DATA && rise) begin
        sr <= cmd[14:0];
        cnt <= cnt + 5'd1;
        if (!rw && cnt == 5'd23) begin
          if (wr_ok) begin
            regs[addr[AW-1:0]] <= cmd[7:0];
            Wr_Stb <= 1'b1;
            Wr_Addr <= addr;
            Wr_Data <= cmd[7:0];
          end else begin
            Frame_Err <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_spi_ad_slave.sv
// tb_spi_ad_slave: directed vector bench driving SPI frames and checking fabric/bus results
module tb_spi_ad_slave;
  localparam int HP = 8;
  logic CLK = 1'b0, RST = 1'b1, SPI_CLK = 1'b0, SPI_CS = 1'b1, SPI_Data_in = 1'b0;
  logic SPI_Data_out, SPI_Data_oe, Wr_Stb, Frame_Err, Busy;
  logic [3:0] Loc_Addr = 4'd0;
  logic [7:0] Loc_q, Wr_Data, last_data, cap;
  logic [12:0] Wr_Addr, last_addr;
  int stb_n, err_n, oe_n, errors = 0, checks = 0;
  typedef struct {
    logic [23:0] f;
    int nb;
    logic rd;
    int stb;
    logic [12:0] a;
    logic [7:0] d;
    int err;
  } vec_t;
  vec_t v[13];
  spi_ad_slave dut (
    .CLK(CLK), .RST(RST), .SPI_CLK(SPI_CLK), .SPI_CS(SPI_CS), .SPI_Data_in(SPI_Data_in),
    .SPI_Data_out(SPI_Data_out), .SPI_Data_oe(SPI_Data_oe), .Loc_Addr(Loc_Addr), .Loc_q(Loc_q),
    .Wr_Stb(Wr_Stb), .Wr_Addr(Wr_Addr), .Wr_Data(Wr_Data), .Frame_Err(Frame_Err), .Busy(Busy)
  );
  always #5 CLK = ~CLK;
  always @(negedge CLK) begin
    if (Wr_Stb) begin
      stb_n++;
      last_addr = Wr_Addr;
      last_data = Wr_Data;
    end
    if (Frame_Err) err_n++;
    if (SPI_Data_oe) oe_n++;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic clr();
    stb_n = 0;
    err_n = 0;
    oe_n = 0;
  endtask
  task automatic bit_out(input logic b, input bit grab);
    SPI_Data_in = b;
    repeat (HP) @(negedge CLK);
    SPI_CLK = 1'b1;
    if (grab) cap = {cap[6:0], SPI_Data_out};
    repeat (HP) @(negedge CLK);
    SPI_CLK = 1'b0;
  endtask
  task automatic frame(input logic [23:0] f, input int nb);
    cap = 8'h00;
    SPI_CS = 1'b0;
    repeat (HP) @(negedge CLK);
    for (int i = 0; i < nb; i++) bit_out(f[23-i], i >= 16);
    repeat (HP) @(negedge CLK);
    SPI_CS = 1'b1;
    repeat (2 * HP) @(negedge CLK);
  endtask
  initial begin
    v[0]  = '{24'h0005A5, 24, 1'b0, 1, 13'h005, 8'hA5, 0};
    v[1]  = '{24'h800500, 24, 1'b1, 0, 13'h000, 8'hA5, 0};
    v[2]  = '{24'h800000, 24, 1'b1, 0, 13'h000, 8'h5A, 0};
    v[3]  = '{24'h0000FF, 24, 1'b0, 0, 13'h000, 8'hFF, 1};
    v[4]  = '{24'h800000, 24, 1'b1, 0, 13'h000, 8'h5A, 0};
    v[5]  = '{24'h010033, 24, 1'b0, 0, 13'h000, 8'h33, 1};
    v[6]  = '{24'h200577, 24, 1'b0, 0, 13'h000, 8'h77, 1};
    v[7]  = '{24'h810000, 24, 1'b1, 0, 13'h000, 8'h00, 1};
    v[8]  = '{24'h800500, 24, 1'b1, 0, 13'h000, 8'hA5, 0};
    v[9]  = '{24'h0003C3, 20, 1'b0, 0, 13'h000, 8'hC3, 0};
    v[10] = '{24'h800300, 24, 1'b1, 0, 13'h000, 8'h00, 0};
    v[11] = '{24'h000F3C, 24, 1'b0, 1, 13'h00F, 8'h3C, 0};
    v[12] = '{24'h800F00, 24, 1'b1, 0, 13'h000, 8'h3C, 0};
    clr();
    repeat (4) @(negedge CLK);
    chk("reset_bus", {SPI_Data_oe, SPI_Data_out, Wr_Stb, Frame_Err, Busy}, 0);
    chk("reset_regs", {Loc_q, Wr_Addr, Wr_Data}, 0);
    RST = 1'b0;
    repeat (2 * HP) @(negedge CLK);
    for (int i = 0; i < 13; i++) begin
      clr();
      frame(v[i].f, v[i].nb);
      chk($sformatf("v%0d_stb", i), stb_n, v[i].stb);
      chk($sformatf("v%0d_err", i), err_n, v[i].err);
      chk($sformatf("v%0d_oe", i), oe_n, v[i].rd ? 128 : 0);
      if (v[i].stb != 0) chk($sformatf("v%0d_wr", i), {last_addr, last_data}, {v[i].a, v[i].d});
      if (v[i].rd) chk($sformatf("v%0d_rd", i), cap, v[i].d);
    end
    Loc_Addr = 4'd5;
    @(negedge CLK);
    chk("loc5", Loc_q, 8'hA5);
    Loc_Addr = 4'd0;
    @(negedge CLK);
    chk("loc0", Loc_q, 8'h5A);
    Loc_Addr = 4'd3;
    @(negedge CLK);
    chk("loc3", Loc_q, 8'h00);
    Loc_Addr = 4'd15;
    @(negedge CLK);
    chk("loc15", Loc_q, 8'h3C);
    SPI_CS = 1'b0;
    repeat (HP) @(negedge CLK);
    for (int i = 0; i < 19; i++) bit_out(i == 0 || i == 13 || i == 15, 1'b0);
    repeat (4) @(negedge CLK);
    chk("pre_rst_oe", SPI_Data_oe, 1'b1);
    RST = 1'b1;
    @(negedge CLK);
    chk("rst_bus", {SPI_Data_oe, SPI_Data_out, Wr_Stb, Frame_Err, Busy}, 0);
    chk("rst_regs", {Loc_q, Wr_Addr, Wr_Data}, 0);
    @(negedge CLK);
    RST = 1'b0;
    clr();
    for (int i = 0; i < 5; i++) bit_out(1'b1, 1'b0);
    repeat (4) @(negedge CLK);
    chk("post_rst_busy", Busy, 1'b0);
    chk("post_rst_quiet", stb_n + err_n + oe_n, 0);
    SPI_CS = 1'b1;
    repeat (2 * HP) @(negedge CLK);
    clr();
    frame(24'h800000, 24);
    chk("post_rst_id", cap, 8'h5A);
    chk("post_rst_id_oe", oe_n, 128);
    @(negedge CLK);
    chk("post_rst_loc15", Loc_q, 8'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
